alu_arbiter: RTL and testbench

Shared-access controller for the 4-bit ALU datapath. It accepts operation requests from two independent requesters over valid/ready handshakes and grants the single ALU round-robin. It drives the ALU operands and opcode from registered state, captures the result, and returns it to the owning requester over a per-requester response handshake. It sits between the two ALU clients and the ALU core, which is combinational and outside this block.

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus between the two ALU clients, the shared ALU core and the arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the clients and the ALU.
interface alu_arbiter_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [W-1:0]     req0_a, req1_a;
    logic [W-1:0]     req0_b, req1_b;
    logic [2:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [W-1:0]     rsp_data;
    logic             rsp_zero;
    logic [W-1:0]     alu_a, alu_b;
    logic [2:0]       alu_op;
    logic [W-1:0]     alu_res;
    logic             busy;
    logic [CNT_W-1:0] cnt0, cnt1;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
               rsp_zero, alu_a, alu_b, alu_op, busy, cnt0, cnt1
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
               rsp_zero, alu_a, alu_b, alu_op, busy, cnt0, cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin owner of the shared combinational ALU for two requesters.
// Each transaction has three phases: grant, execute, then respond.

module alu_arbiter_lane #(
    parameter bit ID    = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             resp_i,
    input  logic             owner_i,
    input  logic             hs_i,
    output logic             rsp_valid_o,
    output logic [CNT_W-1:0] cnt_o
);
    logic             sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sel         = (owner_i == ID);
    assign rsp_valid_o = resp_i && sel;
    assign cnt_d       = (hs_i && sel) ? cnt_q + CNT_W'(1) : cnt_q;
    assign cnt_o       = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

module alu_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                      state_q, state_d;
    logic                        last_grant_q, last_grant_d;
    logic                        owner_q, owner_d;
    logic [W-1:0]                alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]                  alu_op_q, alu_op_d;
    logic [W-1:0]                rsp_data_q, rsp_data_d;
    logic                        rsp_zero_q, rsp_zero_d;

    logic [1:0]                  req_valid, rsp_ready, req_ready, rsp_valid;
    logic [1:0][CNT_W-1:0]       cnt;
    logic                        win, hs, resp;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign resp      = (state_q == RESP);
    assign hs        = resp && rsp_ready[owner_q];

    // A lone requester always wins; a tie goes to whoever was not served last.
    always_comb begin
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ~last_grant_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Ready is also gated by rst_n, so nothing is accepted while reset is held.
                    req_ready[win] = rst_n;
                    owner_d        = win;
                    alu_a_d        = win ? bus.req1_a  : bus.req0_a;
                    alu_b_d        = win ? bus.req1_b  : bus.req0_b;
                    alu_op_d       = win ? bus.req1_op : bus.req0_op;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = bus.alu_res;
                rsp_zero_d = (bus.alu_res == '0);
                state_d    = RESP;
            end
            RESP: begin
                if (hs) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        alu_arbiter_lane #(.ID(1'(g)), .CNT_W(CNT_W)) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .resp_i     (resp),
            .owner_i    (owner_q),
            .hs_i       (hs),
            .rsp_valid_o(rsp_valid[g]),
            .cnt_o      (cnt[g])
        );
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cnt0       = cnt[0];
    assign bus.cnt1       = cnt[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. It plays the ALU core and checks the arbiter against a transaction-level reference.
module tb_alu_arbiter;
    localparam int W = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    alu_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();
    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return ~a;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return 4'd0;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    assign bus.alu_res = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference: at most one outstanding transaction. Its age counts 0 while the ALU
    // evaluates and 1 while the result waits for the owner to take it.
    bit         m_busy, m_own, m_last;
    int         m_age;
    logic [3:0] m_a, m_b, m_res, m_data;
    logic [2:0] m_op;
    bit         m_zero;
    int         m_cnt [2];

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_last = 1; m_age = 0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_data = 0; m_zero = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
        return ~last;
    endfunction

    task automatic model_check();
        bit any, w;
        any = bus.req0_valid || bus.req1_valid;
        w   = pick(bus.req0_valid, bus.req1_valid, m_last);
        chk("req0_ready", 32'(bus.req0_ready), 32'(!m_busy && any && w == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(!m_busy && any && w == 1));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_busy && m_age == 1 && m_own == 0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_busy && m_age == 1 && m_own == 1));
        chk("rsp_data",   32'(bus.rsp_data),   32'(m_data));
        chk("rsp_zero",   32'(bus.rsp_zero),   32'(m_zero));
        chk("alu_a",      32'(bus.alu_a),      32'(m_a));
        chk("alu_b",      32'(bus.alu_b),      32'(m_b));
        chk("alu_op",     32'(bus.alu_op),     32'(m_op));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("cnt0",       32'(bus.cnt0),       32'(m_cnt[0]));
        chk("cnt1",       32'(bus.cnt1),       32'(m_cnt[1]));
    endtask

    task automatic model_update();
        bit any, w;
        any = bus.req0_valid || bus.req1_valid;
        w   = pick(bus.req0_valid, bus.req1_valid, m_last);
        if (!m_busy) begin
            if (any) begin
                m_busy = 1; m_age = 0; m_own = w;
                m_a  = w ? bus.req1_a  : bus.req0_a;
                m_b  = w ? bus.req1_b  : bus.req0_b;
                m_op = w ? bus.req1_op : bus.req0_op;
                m_res = alu_ref(m_a, m_b, m_op);
            end
        end else if (m_age == 0) begin
            m_data = m_res; m_zero = (m_res == 0); m_age = 1;
        end else if (m_own ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_busy = 0; m_last = m_own;
            m_cnt[m_own] = (m_cnt[m_own] + 1) % 256;
        end
    endtask

    task automatic neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic pos();
        model_update();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between clock edges, then releases it just after a rising edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",   32'(bus.busy), 0);
        chk("rst_rdy0",   32'(bus.req0_ready), 0);
        chk("rst_rdy1",   32'(bus.req1_ready), 0);
        chk("rst_rspv0",  32'(bus.rsp0_valid), 0);
        chk("rst_rspv1",  32'(bus.rsp1_valid), 0);
        chk("rst_alu",    32'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
        chk("rst_data",   32'(bus.rsp_data), 0);
        chk("rst_zero",   32'(bus.rsp_zero), 1);
        chk("rst_cnt",    32'({bus.cnt0, bus.cnt1}), 0);
        model_reset();
        @(negedge clk);
        chk("rst_rdy0_hold", 32'(bus.req0_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    endtask

    int gw [16];
    int gc [16];
    int ng;
    logic [3:0] od;
    logic       oz;

    task automatic run_op(input bit r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                          output logic [3:0] d, output logic z);
        idle_inputs();
        if (r) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; end
        else   begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; end
        neg(); pos();
        idle_inputs();
        neg(); pos();
        neg(); d = bus.rsp_data; z = bus.rsp_zero; pos();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset with req0 already waiting, then a single add.
        bus.req0_valid = 1; bus.req0_a = 4'd3; bus.req0_b = 4'd5; bus.req0_op = 3'd0;
        do_reset();
        neg(); chk("add_rdy0", 32'(bus.req0_ready), 1); pos();
        bus.req0_valid = 0;
        neg(); chk("add_alu_a", 32'(bus.alu_a), 3); chk("add_alu_b", 32'(bus.alu_b), 5);
        chk("add_early", 32'(bus.rsp0_valid), 0); pos();
        neg(); chk("add_rspv", 32'(bus.rsp0_valid), 1); chk("add_data", 32'(bus.rsp_data), 8);
        chk("add_zero", 32'(bus.rsp_zero), 0); pos();
        neg(); chk("add_cnt0", 32'(bus.cnt0), 1); pos();

        // Round robin from a fresh reset, with both requesting continuously.
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_op = 3'd0; bus.req1_op = 3'd5;
        do_reset();
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom);
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom);
            neg();
            if (bus.req0_ready && ng < 16) begin gw[ng] = 0; gc[ng] = i; ng++; end
            if (bus.req1_ready && ng < 16) begin gw[ng] = 1; gc[ng] = i; ng++; end
            pos();
        end
        chk("rr_ngrants", 32'(ng >= 4), 1);
        for (int k = 0; k < 4; k++) chk("rr_who", 32'(gw[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++) chk("rr_gap", 32'(gc[k] - gc[k-1]), 3);
        idle_inputs();
        repeat (4) begin neg(); pos(); end

        // Backpressure on requester 1 while requester 0 waits.
        bus.req1_valid = 1; bus.req1_a = 4'd2; bus.req1_b = 4'd5; bus.req1_op = 3'd1;
        bus.rsp1_ready = 0;
        neg(); chk("bp_rdy1", 32'(bus.req1_ready), 1); pos();
        bus.req1_valid = 0; bus.req0_valid = 1; bus.req0_a = 4'd9; bus.req0_b = 4'd9; bus.req0_op = 3'd7;
        neg(); chk("bp_exec_rdy0", 32'(bus.req0_ready), 0); pos();
        for (int i = 0; i < 5; i++) begin
            bus.rsp0_ready = i[0];
            neg();
            chk("bp_data", 32'(bus.rsp_data), 32'hD);
            chk("bp_busy", 32'(bus.busy), 1);
            chk("bp_rdy0", 32'(bus.req0_ready), 0);
            chk("bp_rspv1", 32'(bus.rsp1_valid), 1);
            chk("bp_rspv0", 32'(bus.rsp0_valid), 0);
            pos();
        end
        bus.rsp1_ready = 1;
        neg(); pos();
        neg(); chk("bp_grant0", 32'(bus.req0_ready), 1); pos();
        idle_inputs();
        repeat (3) begin neg(); pos(); end

        // Equality and zero opcodes.
        run_op(1'b0, 4'd7, 4'd7, 3'd7, od, oz);
        chk("eq_data", 32'(od), 1); chk("eq_zero", 32'(oz), 0);
        run_op(1'b1, 4'd7, 4'd3, 3'd6, od, oz);
        chk("zero_data", 32'(od), 0); chk("zero_zero", 32'(oz), 1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            bus.req0_valid = ($urandom_range(0, 3) != 0);
            bus.req1_valid = ($urandom_range(0, 3) != 0);
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_op = 3'($urandom);
            bus.req1_a = 4'($urandom); bus.req1_b = 4'($urandom); bus.req1_op = 3'($urandom);
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
            neg(); pos();
        end

        // 256 back-to-back completions on requester 0 make cnt0 wrap.
        idle_inputs();
        do_reset();
        bus.req0_valid = 1;
        for (int i = 0; i < 767; i++) begin
            bus.req0_a = 4'($urandom); bus.req0_b = 4'($urandom); bus.req0_op = 3'($urandom);
            neg(); pos();
        end
        neg(); chk("wrap_pre", 32'(bus.cnt0), 255); pos();
        neg(); chk("wrap_cnt0", 32'(bus.cnt0), 0); pos();
        idle_inputs();
        repeat (3) begin neg(); pos(); end

        // Reset while a response is pending aborts the transaction.
        bus.req1_valid = 1; bus.req1_a = 4'd4; bus.req1_b = 4'd1; bus.req1_op = 3'd0; bus.rsp1_ready = 0;
        neg(); pos();
        bus.req1_valid = 0;
        neg(); pos();
        neg(); chk("ab_rspv1", 32'(bus.rsp1_valid), 1); pos();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            neg(); chk("ab_noresp", 32'(bus.rsp1_valid), 0); pos();
        end
        chk("ab_cnt", 32'({bus.cnt0, bus.cnt1}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
